mgt_reset_seq: RTL and testbench



---
 rtl/mgt_reset_pkg.sv | 13 +
 rtl/sync_pipe.sv | 16 +
 rtl/mgt_reset_seq.sv | 104 ++++++++++
 tb/tb_mgt_reset_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mgt_reset_pkg.sv
// mgt_reset_pkg: shared state encoding, default timing constants and helpers for the transceiver reset sequencer
package mgt_reset_pkg;
  typedef enum logic [2:0] {IDLE, PLL_RST, WAIT_LOCK, GT_RST, WAIT_DONE, READY, FAIL} state_e;
  localparam int unsigned DEF_SYNC_STAGE       = 2;
  localparam int unsigned DEF_PLL_RESET_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT     = 1024;
  localparam int unsigned DEF_GT_RESET_CYCLES  = 8;
  localparam int unsigned DEF_DONE_TIMEOUT     = 1024;
  localparam int unsigned DEF_MAX_RETRIES      = 3;
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sync_pipe.sv
// sync_pipe: multi-flop synchroniser bringing an asynchronous level into the clk domain
module sync_pipe #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [Stages-1:0] pipe_q, pipe_d;
  always_comb pipe_d = {pipe_q[Stages-2:0], d};
  always_ff @(posedge clk)
    pipe_q <= reset ? {Stages{ResetValue}} : pipe_d;
  assign q = pipe_q[Stages-1];
endmodule

// File: rtl/mgt_reset_seq.sv
// mgt_reset_seq: transceiver channel bring-up sequencer with timeouts, bounded retries and a fault state
module mgt_reset_seq import mgt_reset_pkg::*; #(
  parameter int unsigned SyncStage      = DEF_SYNC_STAGE,
  parameter int unsigned PllResetCycles = DEF_PLL_RESET_CYCLES,
  parameter int unsigned LockTimeout    = DEF_LOCK_TIMEOUT,
  parameter int unsigned GtResetCycles  = DEF_GT_RESET_CYCLES,
  parameter int unsigned DoneTimeout    = DEF_DONE_TIMEOUT,
  parameter int unsigned MaxRetries     = DEF_MAX_RETRIES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pll_lock_async,
  input  logic reset_done_async,
  output logic pll_reset,
  output logic gt_reset,
  output logic userrdy,
  output logic ready,
  output logic error,
  output logic [max2(1, $clog2(MaxRetries+1))-1:0] retry_cnt
);
  localparam int unsigned RW = max2(1, $clog2(MaxRetries+1));
  localparam int unsigned CW = max2(1, $clog2(max2(max2(PllResetCycles, LockTimeout),
                                                   max2(GtResetCycles, DoneTimeout))));
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic lock_s, done_s, retry_go;
  logic pll_reset_q, pll_reset_d, gt_reset_q, gt_reset_d;
  logic userrdy_q, userrdy_d, ready_q, ready_d, error_q, error_d;

  sync_pipe #(.Stages(SyncStage), .ResetValue(1'b0)) u_lock_sync (
    .clk(clk), .reset(reset), .d(pll_lock_async), .q(lock_s));
  sync_pipe #(.Stages(SyncStage), .ResetValue(1'b0)) u_done_sync (
    .clk(clk), .reset(reset), .d(reset_done_async), .q(done_s));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      gt_reset_q  <= 1'b1;
      userrdy_q   <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      gt_reset_q  <= gt_reset_d;
      userrdy_q   <= userrdy_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  // Timeouts and lock loss funnel into retry_go, resolved below in the same transition
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    retry_go = 1'b0;
    unique case (state_q)
      IDLE, FAIL: if (start) begin
        state_d = PLL_RST;
        retry_d = '0;
      end
      PLL_RST:   if (cnt_q == CW'(PllResetCycles-1)) state_d = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_d = GT_RST;
                 else retry_go = cnt_q == CW'(LockTimeout-1);
      GT_RST:    if (!lock_s) retry_go = 1'b1;
                 else if (cnt_q == CW'(GtResetCycles-1)) state_d = WAIT_DONE;
      WAIT_DONE: if (done_s) state_d = READY;
                 else retry_go = !lock_s || cnt_q == CW'(DoneTimeout-1);
      READY:     if (!lock_s) begin
        state_d = PLL_RST;
        retry_d = '0;
      end
      default:   state_d = IDLE;
    endcase
    if (retry_go) begin
      state_d = retry_q == RW'(MaxRetries) ? FAIL : PLL_RST;
      retry_d = retry_q == RW'(MaxRetries) ? retry_q : retry_q + RW'(1);
    end
    cnt_d = state_d != state_q ? '0 : (&cnt_q ? cnt_q : cnt_q + CW'(1));
  end

  // Outputs decoded from the next state so the registered copies line up with state_q
  always_comb begin
    pll_reset_d = state_d inside {IDLE, PLL_RST, FAIL};
    gt_reset_d  = state_d inside {IDLE, PLL_RST, WAIT_LOCK, GT_RST, FAIL};
    userrdy_d   = state_d inside {WAIT_DONE, READY};
    ready_d     = state_d == READY;
    error_d     = state_d == FAIL;
  end

  assign pll_reset = pll_reset_q;
  assign gt_reset  = gt_reset_q;
  assign userrdy   = userrdy_q;
  assign ready     = ready_q;
  assign error     = error_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_mgt_reset_seq.sv
// tb_mgt_reset_seq: directed table plus corner-case sequences for the reset sequencer at default parameters
module tb_mgt_reset_seq;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, lock = 1'b0, done = 1'b0;
  logic pll_reset, gt_reset, userrdy, ready, error;
  logic [1:0] retry_cnt;
  logic [6:0] outs;
  int n_cmp = 0, n_bad = 0;

  // Output patterns {pll_reset, gt_reset, userrdy, ready, error}
  localparam logic [4:0] O_RST = 5'b11000;
  localparam logic [4:0] O_WL  = 5'b01000;
  localparam logic [4:0] O_WD  = 5'b00100;
  localparam logic [4:0] O_RDY = 5'b00110;
  localparam logic [4:0] O_FL  = 5'b11001;

  typedef struct {
    logic rst, st, lk, dn;
    int   n;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[19];

  mgt_reset_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .pll_lock_async(lock), .reset_done_async(done),
    .pll_reset(pll_reset), .gt_reset(gt_reset), .userrdy(userrdy),
    .ready(ready), .error(error), .retry_cnt(retry_cnt));

  always #5 clk = ~clk;
  assign outs = {pll_reset, gt_reset, userrdy, ready, error, retry_cnt};

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (pll,gt,urdy,rdy,err,retry)", name, outs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; lock = 1'b0; done = 1'b0;
    tick_n(2);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 2,  {O_RST, 2'd0}};
    tbl[1]  = '{0, 0, 0, 0, 3,  {O_RST, 2'd0}};
    tbl[2]  = '{0, 1, 0, 0, 1,  {O_RST, 2'd0}};
    tbl[3]  = '{0, 0, 0, 0, 15, {O_RST, 2'd0}};
    tbl[4]  = '{0, 0, 0, 0, 1,  {O_WL,  2'd0}};
    tbl[5]  = '{0, 0, 0, 0, 49, {O_WL,  2'd0}};
    tbl[6]  = '{0, 0, 1, 0, 10, {O_WL,  2'd0}};
    tbl[7]  = '{0, 0, 1, 0, 1,  {O_WD,  2'd0}};
    tbl[8]  = '{0, 0, 1, 0, 19, {O_WD,  2'd0}};
    tbl[9]  = '{0, 0, 1, 1, 2,  {O_WD,  2'd0}};
    tbl[10] = '{0, 0, 1, 1, 1,  {O_RDY, 2'd0}};
    tbl[11] = '{0, 0, 0, 0, 2,  {O_RDY, 2'd0}};
    tbl[12] = '{0, 0, 0, 0, 1,  {O_RST, 2'd0}};
    tbl[13] = '{0, 0, 1, 0, 15, {O_RST, 2'd0}};
    tbl[14] = '{0, 0, 1, 0, 1,  {O_WL,  2'd0}};
    tbl[15] = '{0, 0, 1, 0, 8,  {O_WL,  2'd0}};
    tbl[16] = '{0, 0, 1, 0, 1,  {O_WD,  2'd0}};
    tbl[17] = '{0, 0, 1, 1, 2,  {O_WD,  2'd0}};
    tbl[18] = '{0, 0, 1, 1, 1,  {O_RDY, 2'd0}};
    #1;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; start = tbl[i].st; lock = tbl[i].lk; done = tbl[i].dn;
      tick_n(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Lock never rises: three retries, then FAIL; start recovers
    do_reset();
    start = 1'b1; tick_n(1); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick_n(1039);
      check($sformatf("lock_wait%0d", k), {O_WL, 2'(k-1)});
      tick_n(1);
      check($sformatf("lock_timeout%0d", k), k < 4 ? {O_RST, 2'(k)} : {O_FL, 2'd3});
    end
    start = 1'b1; tick_n(1); start = 1'b0;
    check("fail_restart", {O_RST, 2'd0});
    tick_n(16);
    check("fail_restart_pll_rst", {O_WL, 2'd0});

    // Lock and done arriving on the final timeout cycle
    do_reset();
    start = 1'b1; tick_n(1); start = 1'b0;
    tick_n(16);
    check("sim_wait_lock", {O_WL, 2'd0});
    tick_n(1021); lock = 1'b1;
    tick_n(2);
    check("sim_lock_c1023", {O_WL, 2'd0});
    tick_n(1);
    check("sim_lock_wins", {O_WL, 2'd0});
    tick_n(8);
    check("sim_wait_done", {O_WD, 2'd0});
    tick_n(1021); done = 1'b1;
    tick_n(2);
    check("sim_done_c1023", {O_WD, 2'd0});
    tick_n(1);
    check("sim_done_wins", {O_RDY, 2'd0});

    // start ignored in GT_RST, then reset pulse in WAIT_DONE
    do_reset();
    start = 1'b1; tick_n(1); start = 1'b0; lock = 1'b1;
    tick_n(18);
    start = 1'b1; tick_n(1); start = 1'b0;
    check("gt_rst_start", {O_WL, 2'd0});
    tick_n(6);
    check("start_ignored", {O_WD, 2'd0});
    reset = 1'b1; tick_n(1);
    check("mid_reset", {O_RST, 2'd0});
    reset = 1'b0; tick_n(3);
    check("post_reset_idle", {O_RST, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
